multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit that sequences a shared-memory MIPS datapath: one memory port for instruction and data, one ALU for PC increment, branch target and execution. It replaces the combinational single-cycle Controle decode with a Moore/Mealy state machine. Each instruction takes 3–5 cycles plus memory wait states. The FSM drives every mux select and write enable of the datapath and reports retired and illegal instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instrucao[31:26] from the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination select: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0=PC, 1=rs data
- ALUSrcB  out  2  ALU B select: 00=rt data, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  out  2  to ALUControl: 00=add, 01=sub, 10=funct
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump address
- state  out  4  current state encoding, for debug
- retire  out  1  one-cycle pulse in the last cycle of each legal instruction
- illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Every output not listed for a state is 0.
- States and outputs:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: lw/sw→2, R→6, beq→8, j→9, addi→10, other→FETCH with illegal=1.
  - 2 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw→3, sw→5.
  - 3 MEMREAD: MemRead=1, IorD=1. Holds until mem_ready, then →4.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, retire=1. →0.
  - 5 MEMWRITE: MemWrite=1, IorD=1. Holds until mem_ready. retire=mem_ready. →0 on mem_ready.
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. →7.
  - 7 RCOMPLETE: RegWrite=1, RegDst=1, MemtoReg=0, retire=1. →0.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retire=1. →0.
  - 9 JUMP: PCWrite=1, PCSource=10, retire=1. →0.
  - 10 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. →11.
  - 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, retire=1. →0.
  - Encodings 12–15 are unreachable. If entered, they drive illegal=1 with all enables 0, then go to FETCH.
- opcode is sampled only in DECODE and MEMADDR. The IR is stable there because IRWrite is asserted only in FETCH.
- MemRead and MemWrite are never high in the same cycle. RegWrite is never high in a memory-request cycle.

## Timing
- Reset: state=0 asynchronously. While rst=1, every output except ALUSrcB/ALUOp/PCSource/state is forced to 0, including PCWrite, IRWrite and MemRead regardless of mem_ready. The first FETCH request is issued in the first cycle after rst deasserts.
- Reset asserted mid-instruction aborts it immediately: no retire and no further writes.
- State register updates on the rising edge of clk. Outputs are combinational from state, plus mem_ready in FETCH, MEMWRITE and MEMREAD transitions.
- Latency with mem_ready held at 1, counted from FETCH through the last state:
  - lw = 5 cycles
  - sw, R, addi = 4 cycles
  - beq, j = 3 cycles
  - illegal = 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in all other states.
- The request (MemRead/MemWrite) and IorD stay stable until mem_ready is sampled high.

## Test plan
- Reset mid-EXECUTE with mem_ready=1 → state=0 within the same cycle as rst rises. PCWrite=IRWrite=RegWrite=0 while rst=1. FETCH MemRead=1 appears one cycle after release.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5. retire=1 once.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite=1, IorD=1 for 4 cycles. retire and the return to 0 happen only in the mem_ready cycle. Total 7 cycles.
- R-type, beq, j, addi back-to-back, mem_ready=1 → 4+3+3+4 = 14 cycles and 4 retire pulses. beq shows PCWriteCond=1, PCSource=01. j shows PCWrite=1, PCSource=10.
- Opcode 111111 → FETCH, DECODE with illegal=1, then FETCH. No RegWrite, MemWrite or retire.
- FETCH with mem_ready=0 for 5 cycles → IRWrite=PCWrite=0 throughout. Both are 1 in the single cycle where mem_ready=1, then DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences a shared-memory datapath through
// fetch/decode/execute/memory/writeback states and reports retire/illegal events.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,  S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,  S_RCOMP    = 4'd7,  S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,  S_ADDIEXEC = 4'd10, S_ADDIWB   = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic pcw_c, pcwc_c, iord_c, mr_c, mw_c, irw_c, m2r_c, rd_c, rw_c, asa_c;
  logic ret_c, ill_c;
  logic [1:0] asb_c, aop_c, pcs_c;

  always_comb begin
    state_d = state_q;
    pcw_c = 1'b0; pcwc_c = 1'b0; iord_c = 1'b0; mr_c = 1'b0; mw_c = 1'b0;
    irw_c = 1'b0; m2r_c = 1'b0; rd_c = 1'b0; rw_c = 1'b0; asa_c = 1'b0;
    ret_c = 1'b0; ill_c = 1'b0;
    asb_c = 2'b00; aop_c = 2'b00; pcs_c = 2'b00;
    case (state_q)
      S_FETCH: begin
        mr_c  = 1'b1;
        asb_c = 2'b01;
        irw_c = mem_ready;
        pcw_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        asb_c = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        asa_c = 1'b1;
        asb_c = 2'b10;
        // IR cannot change after DECODE, so anything but lw/sw here is defensive only
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        mr_c   = 1'b1;
        iord_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw_c    = 1'b1;
        m2r_c   = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mw_c   = 1'b1;
        iord_c = 1'b1;
        ret_c  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        asa_c   = 1'b1;
        aop_c   = 2'b10;
        state_d = S_RCOMP;
      end
      S_RCOMP: begin
        rw_c    = 1'b1;
        rd_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        asa_c   = 1'b1;
        aop_c   = 2'b01;
        pcwc_c  = 1'b1;
        pcs_c   = 2'b01;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcw_c   = 1'b1;
        pcs_c   = 2'b10;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        asa_c   = 1'b1;
        asb_c   = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        ill_c   = 1'b1;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Enables are masked during reset so an aborted instruction writes nothing,
  // even though FETCH decode would otherwise follow mem_ready.
  assign PCWrite     = pcw_c  & ~rst;
  assign PCWriteCond = pcwc_c & ~rst;
  assign IorD        = iord_c & ~rst;
  assign MemRead     = mr_c   & ~rst;
  assign MemWrite    = mw_c   & ~rst;
  assign IRWrite     = irw_c  & ~rst;
  assign MemtoReg    = m2r_c  & ~rst;
  assign RegDst      = rd_c   & ~rst;
  assign RegWrite    = rw_c   & ~rst;
  assign ALUSrcA     = asa_c  & ~rst;
  assign retire      = ret_c  & ~rst;
  assign illegal     = ill_c  & ~rst;
  assign ALUSrcB     = asb_c;
  assign ALUOp       = aop_c;
  assign PCSource    = pcs_c;
  assign state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle expected output words.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, retire, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,ASA,ASB,AOP,PCS,ST,RET,ILL}
  function automatic logic [21:0] pk(input logic pcw, pcwc, iord, mr, mw, irw,
      m2r, rd, rw, asa, input logic [1:0] asb, aop, pcs, input logic [3:0] st,
      input logic ret, ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, st, ret, ill};
  endfunction

  logic [21:0] RST, F0, F1, DEC, DECI, MA, MRD, MWB, MWR0, MWR1, EX, RC, BR, JP, AE, AW;
  logic [21:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, retire, illegal};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;
  vec_t tbl[$];

  int nvec = 0, nerr = 0, nret = 0;

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [21:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic inv(input string name);
    chk({name, "_rdwr_excl"}, {21'd0, MemRead & MemWrite}, 22'd0);
    chk({name, "_rw_in_mem"}, {21'd0, RegWrite & (MemRead | MemWrite)}, 22'd0);
  endtask

  initial begin
    RST  = pk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,4'd0,0,0);
    F0   = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,4'd0,0,0);
    F1   = pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,4'd0,0,0);
    DEC  = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,4'd1,0,0);
    DECI = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,4'd1,0,1);
    MA   = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,4'd2,0,0);
    MRD  = pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,4'd3,0,0);
    MWB  = pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,4'd4,1,0);
    MWR0 = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,4'd5,0,0);
    MWR1 = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,4'd5,1,0);
    EX   = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,4'd6,0,0);
    RC   = pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,4'd7,1,0);
    BR   = pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,4'd8,1,0);
    JP   = pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,4'd9,1,0);
    AE   = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,4'd10,0,0);
    AW   = pk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,4'd11,1,0);

    // reset held with mem_ready=1: FETCH enables must stay masked
    tbl.push_back(mk(1, R, 1, RST));   tbl.push_back(mk(1, R, 1, RST));
    // lw, mem_ready=1: 5 cycles
    tbl.push_back(mk(0, LW, 1, F1));   tbl.push_back(mk(0, LW, 1, DEC));
    tbl.push_back(mk(0, LW, 1, MA));   tbl.push_back(mk(0, LW, 1, MRD));
    tbl.push_back(mk(0, LW, 1, MWB));
    // sw with 3 wait cycles in MEMWRITE: 7 cycles
    tbl.push_back(mk(0, SW, 1, F1));   tbl.push_back(mk(0, SW, 0, DEC));
    tbl.push_back(mk(0, SW, 0, MA));   tbl.push_back(mk(0, SW, 0, MWR0));
    tbl.push_back(mk(0, SW, 0, MWR0)); tbl.push_back(mk(0, SW, 0, MWR0));
    tbl.push_back(mk(0, SW, 1, MWR1));
    // R, beq, j, addi back to back: 14 cycles (mem_ready=0 ignored outside memory states)
    tbl.push_back(mk(0, R, 1, F1));    tbl.push_back(mk(0, R, 0, DEC));
    tbl.push_back(mk(0, R, 0, EX));    tbl.push_back(mk(0, R, 0, RC));
    tbl.push_back(mk(0, BEQ, 1, F1));  tbl.push_back(mk(0, BEQ, 1, DEC));
    tbl.push_back(mk(0, BEQ, 1, BR));
    tbl.push_back(mk(0, J, 1, F1));    tbl.push_back(mk(0, J, 1, DEC));
    tbl.push_back(mk(0, J, 1, JP));
    tbl.push_back(mk(0, ADDI, 1, F1)); tbl.push_back(mk(0, ADDI, 1, DEC));
    tbl.push_back(mk(0, ADDI, 1, AE)); tbl.push_back(mk(0, ADDI, 1, AW));
    // illegal opcode: FETCH, DECODE(illegal), FETCH
    tbl.push_back(mk(0, BAD, 1, F1));  tbl.push_back(mk(0, BAD, 1, DECI));
    // FETCH stalled 5 cycles, then an R-type
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, R, 0, F0));
    tbl.push_back(mk(0, R, 1, F1));    tbl.push_back(mk(0, R, 1, DEC));
    tbl.push_back(mk(0, R, 1, EX));    tbl.push_back(mk(0, R, 1, RC));

    rst = 1'b1; opcode = R; mem_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), act, tbl[i].exp);
      inv($sformatf("vec%0d", i));
      if (retire) nret++;
    end
    chk("retire_count", 22'(nret), 22'd7);

    // reset mid-EXECUTE with mem_ready=1: abort immediately
    @(negedge clk); rst = 1'b0; opcode = R; mem_ready = 1'b1; #1;
    chk("abort_fetch", act, F1);
    @(negedge clk); #1; chk("abort_dec", act, DEC);
    @(negedge clk); #1; chk("abort_ex", act, EX);
    #2 rst = 1'b1; #1;
    chk("abort_rst_async", act, RST);
    @(negedge clk); #1; chk("abort_rst_hold", act, RST);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_first_fetch", act, F1);
    @(negedge clk); #1; chk("abort_then_dec", act, DEC);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
